fpga_test_runner: RTL and testbench

Harness-side controller for the `fpga` test-program module, acting as the driving and observing end of its interface.
- Drives the DUT's active-high program reset for a fixed number of cycles, then releases it.
- Waits for the DUT's `finished`, samples `success`, and times out with a watchdog if `finished` never rises.
- Repeats for RUNS runs, then reports aggregate pass/fail on board-level status outputs.

---
 rtl/fpga_test_pkg.sv | 29 ++
 rtl/fpga_test_watchdog.sv | 31 +++
 rtl/fpga_test_runner.sv | 147 ++++++++++++++
 tb/tb_fpga_test_runner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_test_pkg.sv
// Shared types and widths for the fpga test-program harness controller.
package fpga_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    CHECK,
    FIN
  } state_t;

  localparam int RUN_W   = 8;
  localparam int CYCLE_W = 32;

  localparam logic [RUN_W-1:0] COUNT_MAX = '1;

  // Outcome of one program run, captured when the run leaves RUN.
  typedef struct packed {
    logic               finished;
    logic               success;
    logic               timed_out;
    logic [CYCLE_W-1:0] cycles;
  } run_result_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpga_test_watchdog.sv
// Loadable up-counter used to time a program run; terminal marks the last
// allowed cycle (TIMEOUT_CYCLES-1).
module fpga_test_watchdog #(
  parameter int CW             = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpga_test_runner.sv
// Harness controller: resets the program DUT, waits for finished (with a
// watchdog), repeats RUNS times. Option FPGA_TEST_RUNNER_STOP_ON_FAIL_EN ends
// the campaign at the first failing run.
module fpga_test_runner
  import fpga_test_pkg::*;
#(
  parameter int RUNS           = 4,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CW             = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             dut_reset,
  input  logic             dut_finished,
  input  logic             dut_success,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RUN_W-1:0] run_count,
  output logic [RUN_W-1:0] fail_count,
  output logic             timeout_seen,
  output logic [CW-1:0]    cycles_last
);

`ifdef FPGA_TEST_RUNNER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int                 RST_W    = cnt_width(RESET_CYCLES);
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [RUN_W-1:0]   LAST_RUN = RUN_W'(RUNS - 1);

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  run_result_t      result;
  logic [CW-1:0]    wd_count;
  logic             wd_terminal;
  logic             wd_clear;
  logic             wd_enable;
  logic             run_failed;

  // Held at zero through RST so the first RUN cycle always sees count 0.
  assign wd_clear  = (state == RST);
  assign wd_enable = (state == RUN);

  fpga_test_watchdog #(
    .CW             (CW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .clear      (wd_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (wd_enable),
    .count      (wd_count),
    .terminal   (wd_terminal)
  );

  assign run_failed  = result.timed_out || !(result.finished && result.success);
  assign cycles_last = result.cycles[CW-1:0];

  // NOTE: every register here uses <= so all branches read pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dut_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      run_count    <= '0;
      fail_count   <= '0;
      timeout_seen <= 1'b0;
      rst_cnt      <= '0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_reset <= 1'b1;
          if (start) begin
            run_count    <= '0;
            fail_count   <= '0;
            timeout_seen <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            rst_cnt      <= '0;
            state        <= RST;
          end
        end

        RST: begin
          if (rst_cnt == RST_LAST) begin
            dut_reset <= 1'b0;
            state     <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        RUN: begin
          // finished takes priority over a timeout landing in the same cycle.
          if (dut_finished) begin
            result <= '{finished: 1'b1, success: dut_success, timed_out: 1'b0,
                        cycles: CYCLE_W'(wd_count)};
            state  <= CHECK;
          end else if (wd_terminal) begin
            result.finished  <= 1'b0;
            result.success   <= 1'b0;
            result.timed_out <= 1'b1;
            timeout_seen     <= 1'b1;
            state            <= CHECK;
          end
        end

        CHECK: begin
          run_count <= run_count + RUN_W'(1);
          if (run_failed && fail_count != COUNT_MAX) begin
            fail_count <= fail_count + RUN_W'(1);
          end
          dut_reset <= 1'b1;
          if (run_count == LAST_RUN || (STOP_ON_FAIL && run_failed)) begin
            state <= FIN;
          end else begin
            rst_cnt <= '0;
            state   <= RST;
          end
        end

        FIN: begin
          pass      <= (fail_count == '0);
          done      <= 1'b1;
          busy      <= 1'b0;
          dut_reset <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_test_runner.sv
// Directed bench for fpga_test_runner with a behavioural program-DUT stub;
// expected values follow FPGA_TEST_RUNNER_STOP_ON_FAIL_EN when it is defined.
module tb_fpga_test_runner;

  localparam int RUNS           = 4;
  localparam int RESET_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CW             = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          dut_finished;
  logic          dut_success;
  logic          dut_reset;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    run_count;
  logic [7:0]    fail_count;
  logic          timeout_seen;
  logic [CW-1:0] cycles_last;

  int n_checks = 0;
  int n_pass   = 0;

  // Stub configuration and measurements.
  bit fin_en  = 1'b1;
  int fin_lat = 10;
  int bad_run = 0;
  int stub_run = 0;
  int stub_cnt = 0;
  bit prev_rst = 1'b0;
  int hi_cnt   = 0;
  int lo_cnt   = 0;
  int last_lo  = 0;
  int busy_cyc = 0;
  int hi_len [0:8];

  always #5 clock = ~clock;

  fpga_test_runner #(
    .RUNS           (RUNS),
    .RESET_CYCLES   (RESET_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .dut_reset    (dut_reset),
    .dut_finished (dut_finished),
    .dut_success  (dut_success),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .run_count    (run_count),
    .fail_count   (fail_count),
    .timeout_seen (timeout_seen),
    .cycles_last  (cycles_last)
  );

  // Program stub: counts cycles since reset release, raises finished at
  // fin_lat, fails run number bad_run. Updated on the falling edge.
  always @(negedge clock) begin
    if (start && !busy) begin
      stub_run = 0;
      busy_cyc = 0;
    end
    if (busy) busy_cyc++;
    if (dut_reset) begin
      if (!prev_rst) begin
        hi_cnt  = 0;
        last_lo = lo_cnt;
      end
      hi_cnt++;
      stub_cnt     = 0;
      dut_finished = 1'b0;
      dut_success  = 1'b0;
    end else begin
      if (prev_rst) begin
        stub_run++;
        if (stub_run <= 8) hi_len[stub_run] = hi_cnt;
        stub_cnt = 0;
        lo_cnt   = 0;
      end else begin
        stub_cnt++;
      end
      lo_cnt++;
      dut_finished = fin_en && (stub_cnt == fin_lat);
      dut_success  = (stub_run != bad_run);
    end
    prev_rst = dut_reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_dut_reset",    32'(dut_reset),    1);
    check("rst_busy",         32'(busy),         0);
    check("rst_done",         32'(done),         0);
    check("rst_pass",         32'(pass),         0);
    check("rst_run_count",    32'(run_count),    0);
    check("rst_fail_count",   32'(fail_count),   0);
    check("rst_timeout_seen", 32'(timeout_seen), 0);
    check("rst_cycles_last",  32'(cycles_last),  0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // A: every run finishes after 10 cycles with success.
    pulse_start();
    repeat (2) @(negedge clock);
    check("a_busy",      32'(busy),      1);
    check("a_dut_reset", 32'(dut_reset), 1);
    wait_done("a");
    check("a_pass",         32'(pass),         1);
    check("a_run_count",    32'(run_count),    4);
    check("a_fail_count",   32'(fail_count),   0);
    check("a_cycles_last",  32'(cycles_last),  10);
    check("a_timeout_seen", 32'(timeout_seen), 0);
    check("a_busy_low",     32'(busy),         0);
    check("a_hi_len_run2",  32'(hi_len[2]),    4);
    check("a_hi_len_run4",  32'(hi_len[4]),    4);
    // 4 runs x (4 reset + 11 run + 1 check) + 1 fin cycle
    check("a_busy_cycles",  32'(busy_cyc),     65);
    check("a_dut_runs",     32'(stub_run),     4);
    repeat (5) @(negedge clock);
    check("a_done_hold", 32'(done), 1);
    check("a_pass_hold", 32'(pass), 1);

    // B: run 2 reports success=0.
    bad_run = 2;
    pulse_start();
    wait_done("b");
`ifdef FPGA_TEST_RUNNER_STOP_ON_FAIL_EN
    check("b_run_count", 32'(run_count), 2);
`else
    check("b_run_count", 32'(run_count), 4);
`endif
    check("b_fail_count",   32'(fail_count),   1);
    check("b_pass",         32'(pass),         0);
    check("b_timeout_seen", 32'(timeout_seen), 0);

    // C: finished in the same cycle the watchdog expires.
    bad_run = 0;
    fin_lat = 19;
    pulse_start();
    wait_done("c");
    check("c_cycles_last",  32'(cycles_last),  19);
    check("c_timeout_seen", 32'(timeout_seen), 0);
    check("c_fail_count",   32'(fail_count),   0);
    check("c_pass",         32'(pass),         1);
    check("c_busy_cycles",  32'(busy_cyc),     101);

    // D: program never finishes; every run times out.
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("d_rst_cycles_last", 32'(cycles_last), 0);
    @(negedge clock);
    reset  = 1'b1;
    fin_en = 1'b0;
    pulse_start();
    wait_done("d");
    check("d_timeout_seen", 32'(timeout_seen), 1);
    check("d_pass",         32'(pass),         0);
    check("d_cycles_last",  32'(cycles_last),  0);
    // 20 RUN cycles plus the CHECK cycle with the DUT released
    check("d_run_low_len",  32'(last_lo),      21);
`ifdef FPGA_TEST_RUNNER_STOP_ON_FAIL_EN
    check("d_fail_count",   32'(fail_count),   1);
    check("d_run_count",    32'(run_count),    1);
    check("d_busy_cycles",  32'(busy_cyc),     26);
`else
    check("d_fail_count",   32'(fail_count),   4);
    check("d_run_count",    32'(run_count),    4);
    check("d_busy_cycles",  32'(busy_cyc),     101);
`endif

    // E: asynchronous reset in the middle of run 3.
    fin_en  = 1'b1;
    fin_lat = 10;
    pulse_start();
    begin
      int n = 0;
      while (!(stub_run == 3 && !dut_reset) && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    check("e_reached_run3", 32'(stub_run), 3);
    repeat (3) @(negedge clock);
    check("e_mid_run_count", 32'(run_count), 2);
    check("e_mid_dut_reset", 32'(dut_reset), 0);
    #2 reset = 1'b0;
    #1;
    check("e_async_dut_reset",    32'(dut_reset),    1);
    check("e_async_busy",         32'(busy),         0);
    check("e_async_run_count",    32'(run_count),    0);
    check("e_async_cycles_last",  32'(cycles_last),  0);
    check("e_async_done",         32'(done),         0);
    check("e_async_timeout_seen", 32'(timeout_seen), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("e_idle_busy",      32'(busy),      0);
    check("e_idle_dut_reset", 32'(dut_reset), 1);
    pulse_start();
    wait_done("e");
    check("e_run_count", 32'(run_count), 4);
    check("e_pass",      32'(pass),      1);

    // F: a second start during the campaign is ignored.
    pulse_start();
    repeat (20) @(negedge clock);
    check("f_busy_before", 32'(busy), 1);
    pulse_start();
    wait_done("f");
    check("f_run_count",   32'(run_count),  4);
    check("f_fail_count",  32'(fail_count), 0);
    check("f_pass",        32'(pass),       1);
    check("f_busy_cycles", 32'(busy_cyc),   65);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
